// File: rtl/writeback_pkg.sv
// writeback_pkg: state encoding and source slot indices shared by the writeback stage.
package writeback_pkg;
    typedef enum logic {IDLE, WAIT_MEM} state_e;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_IMM = 2;
    localparam int SRC_PC  = 3;
endpackage

// File: rtl/wb_source_mux.sv
// wb_source_mux: selects one packed source slot; out-of-range indices yield zero and raise err.
module wb_source_mux #(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src,
    output logic [DATA_W-1:0]         data,
    output logic                      err
);
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_SRC; k++)
            data = (sel == SEL_W'(k)) ? src[k*DATA_W +: DATA_W] : data;
    end
    assign err = 32'(sel) >= NUM_SRC;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registered N-source writeback with load stall and one-cycle regfile write pulse.
// Define WB_FORWARD_EN to add fwdValid/fwdAddr/fwdData holding the most recent committed write.
module writeback_stage
    import writeback_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SRC = 4,
    parameter  int ADDR_W  = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [SEL_W-1:0]          srcSel,
    input  logic                      regWrite,
    input  logic [ADDR_W-1:0]         destAddr,
    input  logic [NUM_SRC*DATA_W-1:0] srcData,
    input  logic                      memValid,
    output logic                      wbEn,
    output logic [ADDR_W-1:0]         wbAddr,
    output logic [DATA_W-1:0]         wbData,
`ifdef WB_FORWARD_EN
    output logic                      fwdValid,
    output logic [ADDR_W-1:0]         fwdAddr,
    output logic [DATA_W-1:0]         fwdData,
`endif
    output logic                      stall,
    output logic                      selErr
);
    localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(SRC_MEM);
    state_e              state_q, state_d;
    logic                wb_en_q, wb_en_d, sel_err_q, sel_err_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d, pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d, mux_data;
    logic                mux_err;
    wb_source_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) u_mux (
        .sel(srcSel), .src(srcData), .data(mux_data), .err(mux_err)
    );
    always_comb begin
        state_d     = state_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        sel_err_d   = sel_err_q;
        pend_addr_d = pend_addr_q;
        pend_we_d   = pend_we_q;
        if (state_q == IDLE && inValid) begin
            if (srcSel == MEM_SEL && !memValid) begin
                state_d     = WAIT_MEM;
                pend_addr_d = destAddr;
                pend_we_d   = regWrite;
            end else begin
                wb_addr_d = destAddr;
                wb_data_d = mux_data;
                wb_en_d   = regWrite && !mux_err;
                sel_err_d = sel_err_q || mux_err;
            end
        end else if (state_q == WAIT_MEM && memValid) begin
            state_d   = IDLE;
            wb_addr_d = pend_addr_q;
            wb_data_d = srcData[SRC_MEM*DATA_W +: DATA_W];
            wb_en_d   = pend_we_q;
        end
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            sel_err_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            sel_err_q   <= sel_err_d;
            pend_addr_q <= pend_addr_d;
            pend_we_q   <= pend_we_d;
        end
    end
`ifdef WB_FORWARD_EN
    logic                fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
    // Forwarding copy updates in the same cycle wbEn presents the commit.
    always_comb begin
        fwd_valid_d = fwd_valid_q || wb_en_d;
        fwd_addr_d  = wb_en_d ? wb_addr_d : fwd_addr_q;
        fwd_data_d  = wb_en_d ? wb_data_d : fwd_data_q;
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end
    assign fwdValid = fwd_valid_q;
    assign fwdAddr  = fwd_addr_q;
    assign fwdData  = fwd_data_q;
`endif
    assign inReady = state_q == IDLE;
    assign stall   = !inReady;
    assign wbEn    = wb_en_q;
    assign wbAddr  = wb_addr_q;
    assign wbData  = wb_data_q;
    assign selErr  = sel_err_q;
endmodule
